// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access pipeline stage: bus widths, memory-op codes,
// FSM states and small op-decoding helpers.
package mem_stage_pkg;

  localparam int RegW     = 32;
  localparam int RegAddrW = 5;
  localparam int MemOpW   = 4;

  localparam logic [RegW-1:0] ZeroWord = '0;

  typedef enum logic [MemOpW-1:0] {
    MemNop = 4'd0,
    Lb     = 4'd1,
    Lh     = 4'd2,
    Lw     = 4'd3,
    Lbu    = 4'd4,
    Lhu    = 4'd5,
    Sb     = 4'd6,
    Sh     = 4'd7,
    Sw     = 4'd8
  } memop_e;

  typedef enum logic [1:0] {
    MemIdle   = 2'd0,
    MemAccess = 2'd1,
    MemDone   = 2'd2
  } state_e;

  // Unassigned op codes are treated like MemNop and pass straight through.
  function automatic logic is_mem_op(input logic [MemOpW-1:0] op);
    return op inside {Lb, Lh, Lw, Lbu, Lhu, Sb, Sh, Sw};
  endfunction

  function automatic logic is_store(input logic [MemOpW-1:0] op);
    return op inside {Sb, Sh, Sw};
  endfunction

  // Index of the final byte of the access (byte count minus one).
  function automatic logic [1:0] last_idx(input logic [MemOpW-1:0] op);
    logic [1:0] idx;
    case (op)
      Lb, Lbu, Sb: idx = 2'd0;
      Lh, Lhu, Sh: idx = 2'd1;
      default:     idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Sign/zero extension of the little-endian assembly register according to the load op.
module mem_load_ext
  import mem_stage_pkg::*;
(
  input  memop_e          i_op,
  input  logic [RegW-1:0] i_asm,
  output logic [RegW-1:0] o_data
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    o_data = i_asm;
    case (i_op)
      Lb:      o_data = {{24{i_asm[7]}}, i_asm[7:0]};
      Lh:      o_data = {{16{i_asm[15]}}, i_asm[15:0]};
      Lbu:     o_data = {24'd0, i_asm[7:0]};
      Lhu:     o_data = {16'd0, i_asm[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers ALU results through, and performs loads and
// stores byte-serially over a request/acknowledge port, stalling the pipeline meanwhile.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int BYTE_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [RegAddrW-1:0] wd_i,
  input  logic                wreg_i,
  input  logic [RegW-1:0]     data_i,
  input  logic [MemOpW-1:0]   memop_i,
  input  logic [RegW-1:0]     store_data_i,
  output logic                valid_o,
  output logic [RegAddrW-1:0] wd_o,
  output logic                wreg_o,
  output logic [RegW-1:0]     data_o,
  output logic                stall_req_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [RegW-1:0]     mem_addr_o,
  output logic [BYTE_W-1:0]   mem_wdata_o,
  input  logic                mem_ack_i,
  input  logic [BYTE_W-1:0]   mem_rdata_i
);

  state_e              r_state, w_state_nxt;
  logic                r_valid;
  logic [RegAddrW-1:0] r_wd, r_lwd;
  logic                r_wreg, r_lwreg;
  logic [RegW-1:0]     r_data, r_base, r_sdata, r_asm;
  memop_e              r_op;
  logic [1:0]          r_last, r_k;
  logic [RegW-1:0]     w_ext;
  logic                w_accept_mem;

  assign w_accept_mem = valid_i && is_mem_op(memop_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= MemIdle;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MemIdle:   if (w_accept_mem) w_state_nxt = MemAccess;
      MemAccess: if (mem_ack_i && (r_k == r_last)) w_state_nxt = MemDone;
      MemDone:   w_state_nxt = MemIdle;
      default:   w_state_nxt = MemIdle;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_wd    <= '0;
      r_wreg  <= 1'b0;
      r_data  <= ZeroWord;
      r_base  <= ZeroWord;
      r_sdata <= ZeroWord;
      r_asm   <= ZeroWord;
      r_op    <= MemNop;
      r_lwd   <= '0;
      r_lwreg <= 1'b0;
      r_last  <= 2'd0;
      r_k     <= 2'd0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        MemIdle: begin
          if (valid_i && !is_mem_op(memop_i)) begin
            r_valid <= 1'b1;
            r_wd    <= wd_i;
            r_wreg  <= wreg_i;
            r_data  <= data_i;
          end else if (w_accept_mem) begin
            r_base  <= data_i;
            r_sdata <= store_data_i;
            r_op    <= memop_e'(memop_i);
            r_lwd   <= wd_i;
            r_lwreg <= wreg_i;
            r_last  <= last_idx(memop_i);
            r_k     <= 2'd0;
            r_asm   <= ZeroWord;
          end
        end
        MemAccess: begin
          if (mem_ack_i) begin
            if (!is_store(r_op)) r_asm[r_k*BYTE_W +: BYTE_W] <= mem_rdata_i;
            if (r_k != r_last)   r_k <= r_k + 2'd1;
          end
        end
        MemDone: begin
          r_valid <= 1'b1;
          r_wd    <= r_lwd;
          r_wreg  <= is_store(r_op) ? 1'b0 : r_lwreg;
          r_data  <= is_store(r_op) ? ZeroWord : w_ext;
        end
        default: ;
      endcase
    end
  end

  mem_load_ext u_load_ext (
    .i_op   (r_op),
    .i_asm  (r_asm),
    .o_data (w_ext)
  );

  assign ready_o     = (r_state == MemIdle);
  assign stall_req_o = (r_state != MemIdle);
  assign mem_req_o   = (r_state == MemAccess);
  assign mem_we_o    = (r_state == MemAccess) && is_store(r_op);
  assign mem_addr_o  = r_base + {30'd0, r_k};
  assign mem_wdata_o = r_sdata[r_k*BYTE_W +: BYTE_W];

  assign valid_o = r_valid;
  assign wd_o    = r_wd;
  assign wreg_o  = r_wreg;
  assign data_o  = r_data;

endmodule
